// File: rtl/tlx_fwd_link_arbiter_if.sv
// Bundle of the requester-side streams, the TLX forward payload channel and the
// TLX forward flow (credit-return) channel shared by the link arbiter.
interface tlx_fwd_link_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 40
);
  logic [NUM_REQ-1:0]        req_tvalid;
  logic [NUM_REQ-1:0]        req_tready;
  logic [NUM_REQ*DATA_W-1:0] req_tdata;
  logic [NUM_REQ-1:0]        req_tlast;

  logic                      tlx_fwd_payload_tvalid;
  logic                      tlx_fwd_payload_tready;
  logic [DATA_W-1:0]         tlx_fwd_payload_tdata;

  logic                      tlx_fwd_flow_tvalid;
  logic                      tlx_fwd_flow_tready;
  logic [1:0]                tlx_fwd_flow_tdata;

  // Arbiter view.
  modport slave (
    input  req_tvalid, req_tdata, req_tlast,
    output req_tready,
    output tlx_fwd_payload_tvalid, tlx_fwd_payload_tdata,
    input  tlx_fwd_payload_tready,
    input  tlx_fwd_flow_tvalid, tlx_fwd_flow_tdata,
    output tlx_fwd_flow_tready
  );

  // Requester / pad-frame view.
  modport master (
    output req_tvalid, req_tdata, req_tlast,
    input  req_tready,
    input  tlx_fwd_payload_tvalid, tlx_fwd_payload_tdata,
    output tlx_fwd_payload_tready,
    output tlx_fwd_flow_tvalid, tlx_fwd_flow_tdata,
    input  tlx_fwd_flow_tready
  );
endinterface

// File: rtl/tlx_fwd_link_arbiter.sv
// Packet-level round-robin arbiter for the TLX forward payload channel, with
// credit metering replenished by returns on the TLX forward flow channel.
module tlx_fwd_link_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_W      = 40,
  parameter int unsigned CREDIT_INIT = 16,
  parameter int unsigned CREDIT_W    = 6
) (
  input  logic                       tlx_fwd_clk,
  input  logic                       tlx_fwd_reset,
  tlx_fwd_link_arbiter_if.slave      link,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [CREDIT_W-1:0]        credit_count,
  output logic                       credit_overflow
);
  localparam int unsigned GNT_W = $clog2(NUM_REQ);
  localparam logic [GNT_W-1:0]    LAST_RST   = GNT_W'(NUM_REQ - 1);
  localparam logic [CREDIT_W-1:0] CREDIT_RST = CREDIT_W'(CREDIT_INIT);
  localparam logic [CREDIT_W:0]   CREDIT_MAX = (CREDIT_W + 1)'(CREDIT_INIT);

  typedef enum logic {IDLE, BURST} state_e;

  state_e              state_q, state_d;
  logic [GNT_W-1:0]    grant_q, grant_d;
  logic [GNT_W-1:0]    last_q, last_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                ovf_q, ovf_d;

  logic                credit_ok;
  logic                accept;
  logic                found;
  logic [GNT_W-1:0]    idx;
  logic [CREDIT_W:0]   credit_sum;

  // Credit returns are never back-pressured outside reset.
  assign link.tlx_fwd_flow_tready = ~tlx_fwd_reset;

  assign grant_id        = grant_q;
  assign credit_count    = credit_q;
  assign credit_overflow = ovf_q;

  always_comb begin
    state_d                     = state_q;
    grant_d                     = grant_q;
    last_d                      = last_q;
    link.req_tready             = '0;
    link.tlx_fwd_payload_tvalid = 1'b0;
    link.tlx_fwd_payload_tdata  = '0;
    accept                      = 1'b0;
    found                       = 1'b0;
    idx                         = '0;
    credit_ok                   = (credit_q != '0);

    case (state_q)
      IDLE: begin
        if (credit_ok && (|link.req_tvalid)) begin
          // Scan starts one past the last packet owner so every requester rotates to top priority.
          for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = GNT_W'((32'(last_q) + i) % NUM_REQ);
            if (!found && link.req_tvalid[idx]) begin
              found   = 1'b1;
              grant_d = idx;
            end
          end
          state_d = BURST;
        end
      end
      BURST: begin
        link.tlx_fwd_payload_tvalid = link.req_tvalid[grant_q] & credit_ok;
        if (link.tlx_fwd_payload_tvalid) begin
          link.tlx_fwd_payload_tdata = link.req_tdata[grant_q*DATA_W +: DATA_W];
        end
        link.req_tready[grant_q] = link.tlx_fwd_payload_tready & credit_ok;
        accept = link.tlx_fwd_payload_tvalid & link.tlx_fwd_payload_tready;
        if (accept && link.req_tlast[grant_q]) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    credit_sum = {1'b0, credit_q} - (CREDIT_W + 1)'(accept)
               + (link.tlx_fwd_flow_tvalid ? (CREDIT_W + 1)'(link.tlx_fwd_flow_tdata) : '0);
    credit_d   = credit_sum[CREDIT_W-1:0];
    ovf_d      = ovf_q;
    if (credit_sum > CREDIT_MAX) begin
      credit_d = CREDIT_RST;
      ovf_d    = 1'b1;
    end
  end

  always_ff @(posedge tlx_fwd_clk) begin
    if (tlx_fwd_reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= LAST_RST;
      credit_q <= CREDIT_RST;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_tlx_fwd_link_arbiter.sv
// Directed bench for tlx_fwd_link_arbiter: one default-credit instance and one
// instance with CREDIT_INIT=2 for the credit-exhaustion scenario.
module tb_tlx_fwd_link_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [1:0] gnt_a, gnt_b;
  logic [5:0] cred_a, cred_b;
  logic       ovf_a, ovf_b;

  tlx_fwd_link_arbiter_if #(.NUM_REQ(4), .DATA_W(40)) ia ();
  tlx_fwd_link_arbiter_if #(.NUM_REQ(4), .DATA_W(40)) ib ();

  tlx_fwd_link_arbiter #(.NUM_REQ(4), .DATA_W(40), .CREDIT_INIT(16), .CREDIT_W(6)) u_dut_a (
    .tlx_fwd_clk(clk), .tlx_fwd_reset(rst), .link(ia.slave),
    .grant_id(gnt_a), .credit_count(cred_a), .credit_overflow(ovf_a)
  );

  tlx_fwd_link_arbiter #(.NUM_REQ(4), .DATA_W(40), .CREDIT_INIT(2), .CREDIT_W(6)) u_dut_b (
    .tlx_fwd_clk(clk), .tlx_fwd_reset(rst), .link(ib.slave),
    .grant_id(gnt_b), .credit_count(cred_b), .credit_overflow(ovf_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // All four requesters post nb-beat packets at once; beats must arrive
  // packet by packet in order 0,1,2,3. Beat b of requester i carries i*16+b.
  task automatic run_round(input int nb);
    int beat[4];
    int exp_idx;
    int cyc;
    for (int i = 0; i < 4; i++) beat[i] = 0;
    exp_idx = 0;
    cyc     = 0;
    ia.tlx_fwd_payload_tready = 1'b1;
    while (exp_idx < 4 * nb && cyc < 100) begin
      for (int i = 0; i < 4; i++) begin
        ia.req_tvalid[i]          = (beat[i] < nb);
        ia.req_tdata[i*40 +: 40]  = 40'(i * 16 + beat[i]);
        ia.req_tlast[i]           = (beat[i] == nb - 1);
      end
      @(negedge clk);
      if (ia.tlx_fwd_payload_tvalid && ia.tlx_fwd_payload_tready) begin
        chk("rr_data", ia.tlx_fwd_payload_tdata, 64'((exp_idx / nb) * 16 + (exp_idx % nb)));
        chk("rr_grant", gnt_a, 64'(exp_idx / nb));
        exp_idx++;
      end
      for (int i = 0; i < 4; i++) begin
        if (ia.req_tready[i] && ia.req_tvalid[i]) beat[i]++;
      end
      step();
      cyc++;
    end
    if (exp_idx < 4 * nb) chk("rr_timeout", 64'(exp_idx), 64'(4 * nb));
    ia.req_tvalid = '0;
    ia.req_tlast  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ia.req_tvalid = '0; ia.req_tdata = '0; ia.req_tlast = '0;
    ia.tlx_fwd_payload_tready = 1'b0; ia.tlx_fwd_flow_tvalid = 1'b0; ia.tlx_fwd_flow_tdata = '0;
    ib.req_tvalid = '0; ib.req_tdata = '0; ib.req_tlast = '0;
    ib.tlx_fwd_payload_tready = 1'b0; ib.tlx_fwd_flow_tvalid = 1'b0; ib.tlx_fwd_flow_tdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", ia.tlx_fwd_payload_tvalid, 1'b0);
    chk("rst_tdata", ia.tlx_fwd_payload_tdata, 40'h0);
    chk("rst_credit", cred_a, 6'd16);
    chk("rst_grant", gnt_a, 2'd0);
    chk("rst_ovf", ovf_a, 1'b0);
    chk("rst_tready", ia.req_tready, 4'b0000);
    chk("rst_flow_tready", ia.tlx_fwd_flow_tready, 1'b0);
    step();
    rst = 1'b0;

    // Test 1: requester 0, three beats A0..A2
    ia.req_tvalid = 4'b0001;
    ia.req_tdata[0 +: 40] = 40'hA0;
    ia.req_tlast = 4'b0000;
    ia.tlx_fwd_payload_tready = 1'b1;
    @(negedge clk);
    chk("t1_idle_tvalid", ia.tlx_fwd_payload_tvalid, 1'b0);
    chk("t1_idle_tready", ia.req_tready, 4'b0000);
    chk("t1_flow_tready", ia.tlx_fwd_flow_tready, 1'b1);
    step();
    for (int b = 0; b < 3; b++) begin
      ia.req_tdata[0 +: 40] = 40'(8'hA0 + b);
      ia.req_tlast[0] = (b == 2);
      @(negedge clk);
      chk("t1_tvalid", ia.tlx_fwd_payload_tvalid, 1'b1);
      chk("t1_tdata", ia.tlx_fwd_payload_tdata, 64'(8'hA0 + b));
      chk("t1_tready", ia.req_tready, 4'b0001);
      step();
    end
    ia.req_tvalid = '0;
    ia.req_tlast  = '0;
    @(negedge clk);
    chk("t1_credit", cred_a, 6'd13);
    chk("t1_done_tvalid", ia.tlx_fwd_payload_tvalid, 1'b0);
    chk("t1_grant", gnt_a, 2'd0);
    // last_grant=0 means requester 1 now beats requester 0
    ia.req_tvalid = 4'b0011;
    ia.req_tlast  = 4'b0011;
    ia.req_tdata[0 +: 40]  = 40'hC0;
    ia.req_tdata[40 +: 40] = 40'hC1;
    step();
    @(negedge clk);
    chk("t1_rr_grant", gnt_a, 2'd1);
    chk("t1_rr_tdata", ia.tlx_fwd_payload_tdata, 40'hC1);
    chk("t1_rr_tready", ia.req_tready, 4'b0010);
    step();
    ia.req_tvalid = '0;
    ia.req_tlast  = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Test 2: four simultaneous 2-beat packets, twice
    run_round(2);
    run_round(2);
    @(negedge clk);
    chk("t2_credit", cred_a, 6'd0);

    // Test 4: credit returns, simultaneous consume+return, saturation
    step();
    ia.tlx_fwd_flow_tvalid = 1'b1;
    ia.tlx_fwd_flow_tdata  = 2'd3;
    repeat (3) step();
    ia.tlx_fwd_flow_tdata  = 2'd1;
    step();
    ia.tlx_fwd_flow_tvalid = 1'b0;
    @(negedge clk);
    chk("t4_credit10", cred_a, 6'd10);
    ia.req_tvalid = 4'b0001;
    ia.req_tlast  = 4'b0001;
    ia.req_tdata[0 +: 40] = 40'h44;
    step();
    ia.tlx_fwd_flow_tvalid = 1'b1;
    ia.tlx_fwd_flow_tdata  = 2'd3;
    @(negedge clk);
    chk("t4_beat_tvalid", ia.tlx_fwd_payload_tvalid, 1'b1);
    step();
    ia.req_tvalid = '0;
    ia.req_tlast  = '0;
    @(negedge clk);
    chk("t4_credit12", cred_a, 6'd12);
    chk("t4_ovf_clear", ovf_a, 1'b0);
    step();
    @(negedge clk);
    chk("t4_credit15", cred_a, 6'd15);
    chk("t4_ovf_clear15", ovf_a, 1'b0);
    step();
    ia.tlx_fwd_flow_tvalid = 1'b0;
    @(negedge clk);
    chk("t4_credit_sat", cred_a, 6'd16);
    chk("t4_ovf_set", ovf_a, 1'b1);
    step();
    @(negedge clk);
    chk("t4_ovf_sticky", ovf_a, 1'b1);
    chk("t4_credit_hold", cred_a, 6'd16);

    // Test 5: link back-pressure mid-packet
    ia.req_tvalid = 4'b0100;
    ia.req_tlast  = 4'b0000;
    ia.req_tdata[80 +: 40] = 40'h50;
    ia.tlx_fwd_payload_tready = 1'b1;
    step();
    @(negedge clk);
    chk("t5_first", ia.tlx_fwd_payload_tdata, 40'h50);
    chk("t5_grant", gnt_a, 2'd2);
    step();
    ia.req_tdata[80 +: 40] = 40'h51;
    ia.tlx_fwd_payload_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_stall_tvalid", ia.tlx_fwd_payload_tvalid, 1'b1);
      chk("t5_stall_tdata", ia.tlx_fwd_payload_tdata, 40'h51);
      chk("t5_stall_credit", cred_a, 6'd15);
      chk("t5_stall_grant", gnt_a, 2'd2);
      chk("t5_stall_tready", ia.req_tready, 4'b0000);
      step();
    end
    ia.tlx_fwd_payload_tready = 1'b1;
    @(negedge clk);
    chk("t5_resume", ia.tlx_fwd_payload_tdata, 40'h51);
    step();
    ia.req_tdata[80 +: 40] = 40'h52;
    ia.req_tlast = 4'b0100;
    @(negedge clk);
    chk("t5_last", ia.tlx_fwd_payload_tdata, 40'h52);
    step();
    ia.req_tvalid = '0;
    ia.req_tlast  = '0;
    @(negedge clk);
    chk("t5_credit", cred_a, 6'd13);

    // Test 6: reset mid-packet
    ia.req_tvalid = 4'b1000;
    ia.req_tdata[120 +: 40] = 40'h60;
    step();
    @(negedge clk);
    chk("t6_grant3", gnt_a, 2'd3);
    chk("t6_tvalid", ia.tlx_fwd_payload_tvalid, 1'b1);
    step();
    ia.req_tdata[120 +: 40] = 40'h61;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ia.req_tvalid = 4'b1001;
    ia.req_tlast  = 4'b0001;
    ia.req_tdata[0 +: 40] = 40'h70;
    @(negedge clk);
    chk("t6_tvalid_after", ia.tlx_fwd_payload_tvalid, 1'b0);
    chk("t6_credit", cred_a, 6'd16);
    chk("t6_ovf", ovf_a, 1'b0);
    chk("t6_tready", ia.req_tready, 4'b0000);
    step();
    @(negedge clk);
    chk("t6_regrant", gnt_a, 2'd0);
    chk("t6_regrant_tdata", ia.tlx_fwd_payload_tdata, 40'h70);
    step();
    ia.req_tvalid = '0;
    ia.req_tlast  = '0;
    ia.tlx_fwd_payload_tready = 1'b0;

    // Test 3: CREDIT_INIT=2 instance, 4-beat packet from requester 1
    ib.req_tvalid = 4'b0010;
    ib.req_tlast  = 4'b0000;
    ib.req_tdata[40 +: 40] = 40'hB0;
    ib.tlx_fwd_payload_tready = 1'b1;
    @(negedge clk);
    chk("t3_credit_init", cred_b, 6'd2);
    step();
    @(negedge clk);
    chk("t3_b0", ib.tlx_fwd_payload_tdata, 40'hB0);
    step();
    ib.req_tdata[40 +: 40] = 40'hB1;
    @(negedge clk);
    chk("t3_b1", ib.tlx_fwd_payload_tdata, 40'hB1);
    step();
    ib.req_tdata[40 +: 40] = 40'hB2;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t3_stall_tvalid", ib.tlx_fwd_payload_tvalid, 1'b0);
      chk("t3_stall_tdata", ib.tlx_fwd_payload_tdata, 40'h0);
      chk("t3_stall_grant", gnt_b, 2'd1);
      chk("t3_stall_credit", cred_b, 6'd0);
      chk("t3_stall_tready", ib.req_tready, 4'b0000);
      step();
    end
    ib.tlx_fwd_flow_tvalid = 1'b1;
    ib.tlx_fwd_flow_tdata  = 2'd2;
    @(negedge clk);
    chk("t3_ret_tvalid", ib.tlx_fwd_payload_tvalid, 1'b0);
    step();
    ib.tlx_fwd_flow_tvalid = 1'b0;
    @(negedge clk);
    chk("t3_credit2", cred_b, 6'd2);
    chk("t3_b2", ib.tlx_fwd_payload_tdata, 40'hB2);
    chk("t3_b2_grant", gnt_b, 2'd1);
    step();
    ib.req_tdata[40 +: 40] = 40'hB3;
    ib.req_tlast = 4'b0010;
    @(negedge clk);
    chk("t3_b3", ib.tlx_fwd_payload_tdata, 40'hB3);
    chk("t3_credit1", cred_b, 6'd1);
    step();
    ib.req_tvalid = '0;
    ib.req_tlast  = '0;
    @(negedge clk);
    chk("t3_credit0", cred_b, 6'd0);
    chk("t3_done_tvalid", ib.tlx_fwd_payload_tvalid, 1'b0);
    chk("t3_ovf", ovf_b, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tlx_fwd_link_arbiter.md
Name: tlx_fwd_link_arbiter

Overview:
- Shares the single 40-bit TLX forward payload channel between NUM_REQ on-chip requesters.
- Arbitration is packet-level round-robin: a grant is held until the requester's tlast beat is accepted.
- Beats are metered by a credit counter. The counter is replenished by credit returns arriving on the TLX forward flow channel.
- Sits between the SoC-side TLX requesters and the pad-frame TLX FWD payload/flow pins, in the tlx_fwd_clk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 40, payload width in bits.
- CREDIT_INIT, 16, credits loaded at reset; also the saturation maximum.
- CREDIT_W, 6, credit counter width; must hold CREDIT_INIT.

Ports:
- tlx_fwd_clk  in  1  link clock; all logic is on the rising edge.
- tlx_fwd_reset  in  1  synchronous, active-high reset.
- req_tvalid  in  NUM_REQ  per-requester beat valid.
- req_tready  out  NUM_REQ  per-requester beat accept.
- req_tdata  in  NUM_REQ*DATA_W  per-requester payload; requester i occupies slice [i*DATA_W +: DATA_W].
- req_tlast  in  NUM_REQ  marks the last beat of a packet.
- tlx_fwd_payload_tvalid  out  1  link beat valid.
- tlx_fwd_payload_tready  in  1  link beat accept.
- tlx_fwd_payload_tdata  out  DATA_W  link payload.
- tlx_fwd_flow_tvalid  in  1  credit-return valid.
- tlx_fwd_flow_tready  out  1  credit-return accept.
- tlx_fwd_flow_tdata  in  2  number of credits returned (0..3).
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester.
- credit_count  out  CREDIT_W  available credits.
- credit_overflow  out  1  sticky error flag.

Behaviour:
- Reset values:
  - state=IDLE.
  - credit_count=CREDIT_INIT.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - grant_id=0.
  - All req_tready=0, payload_tvalid=0, payload_tdata=0.
  - flow_tready=0, credit_overflow=0.
- Reset mid-packet: the burst is abandoned with no further beats, and all state returns to its reset values.
- flow_tready: 1 in every cycle after reset deasserts; credit returns are never back-pressured.
- IDLE state:
  - If any req_tvalid=1 and credit_count>0: select the first requester with tvalid=1, scanning from last_grant+1 modulo NUM_REQ.
  - Register the winner into grant_id and move to BURST.
  - No beat is transferred in the IDLE cycle; first-beat latency is 1 cycle from the request.
  - If credit_count=0, stay in IDLE.
- BURST state (grant g):
  - payload_tvalid = req_tvalid[g] AND (credit_count>0).
  - payload_tdata = slice g of req_tdata when payload_tvalid=1, otherwise 0.
  - req_tready[g] = payload_tready AND (credit_count>0); all other req_tready=0.
  - payload_tvalid never depends on payload_tready.
  - Accept = payload_tvalid AND payload_tready.
  - Accept with req_tlast[g]=1: last_grant<=g and state<=IDLE.
  - Accept with req_tlast[g]=0: stay in BURST.
- Credit exhaustion mid-packet: payload_tvalid is forced to 0 and the grant is held. No other requester may interleave.
- Credit arithmetic, evaluated every cycle:
  - next = credit_count − accept + (flow_tvalid ? flow_tdata : 0).
  - The computation uses CREDIT_W+1 bits.
  - A simultaneous consume and return are both applied in the same cycle.
  - If next > CREDIT_INIT: credit_count<=CREDIT_INIT and credit_overflow<=1. credit_overflow stays at 1 until reset.
- Underflow is impossible because accept requires credit_count>0.
- A requester with tvalid=0 inside BURST stalls the link. The grant is not released until its tlast beat is accepted.
- Ungranted requesters are never acknowledged, including while the arbiter is in IDLE.

Test Plan:
1. Requester 0 sends 3 beats (data 0xA0..0xA2, tlast on 3rd); link tready=1 throughout -> link carries 0xA0, 0xA1, 0xA2 on consecutive cycles starting 1 cycle after the first tvalid; credit_count goes 16 -> 13; returns to IDLE with last_grant=0.
2. Requesters 0..3 all post 2-beat packets simultaneously -> grant order 0,1,2,3, with no beat of one packet interleaved into another; a repeat of the stimulus again yields order 0,1,2,3.
3. CREDIT_INIT=2, requester 1 sends a 4-beat packet -> 2 beats transfer, then payload_tvalid=0 with grant_id=1 held; a flow return of 2 resumes the remaining beats with count 0 -> 2 -> 0.
4. In one cycle, a beat is accepted and a flow return of 3 arrives with count 10 -> count becomes 12; at count 15 a return of 3 -> count saturates at 16 and credit_overflow=1 stays set.
5. Link tready held 0 for 5 cycles mid-packet -> payload_tvalid and tdata stay stable, count is unchanged, and grant_id is unchanged.
6. Reset asserted for 1 cycle mid-packet -> the next cycle shows payload_tvalid=0 and credit_count=16; the next arbitration grants requester 0 first.
